vinstru_reader: RTL and testbench
=================================

VINSTRU_READER -- requirements
Module: vinstru_reader

Interface
REQ-001 Parameter: Wdepth, default 4096; capture BRAM depth in 32-bit words, power of two.
REQ-002 Parameter: RD_LATENCY, default 1; BRAM read latency in cycles, legal values 1 or 2.
REQ-003 Parameter: FIFO_DEPTH, default 4; output buffer depth in words, power of two, at least RD_LATENCY+2.
REQ-004 clk  in  1  sole clock; the BRAM port is driven on this clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a readout.
REQ-007 abort  in  1  terminates the readout in progress.
REQ-008 start_addr  in  log2(Wdepth)  first word address.
REQ-009 length  in  log2(Wdepth)+1  number of words to read.
REQ-010 busy  out  1  high from the accepted start until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 bram_clk  out  1  equals clk.
REQ-013 bram_rst  out  1  equals ~resetn.
REQ-014 bram_en  out  1  read enable.
REQ-015 bram_we  out  4  held at 0.
REQ-016 bram_addr  out  log2(Wdepth)+2  byte address, i.e. word address followed by two zero LSBs.
REQ-017 bram_din  out  32  held at 0.
REQ-018 bram_dout  in  32  read data, valid RD_LATENCY cycles after bram_en.
REQ-019 m_axis_tdata  out  32  stream data.
REQ-020 m_axis_tvalid  out  1  stream valid.
REQ-021 m_axis_tready  in  1  stream ready.
REQ-022 m_axis_tlast  out  1  marks the final word of a readout.

Function
REQ-023 The FSM SHALL use four states: IDLE, READ, DRAIN and FIN.
REQ-024 In IDLE, start=1 SHALL latch start_addr and the effective length (min(length, Wdepth)), then move to READ; busy rises on the next cycle.
REQ-025 start SHALL be ignored while not in IDLE.
REQ-026 start with length=0 SHALL go directly to FIN: no BRAM reads, no stream beats.
REQ-027 In READ, one bram_en read SHALL be issued per cycle only while (words in flight + FIFO occupancy) < FIFO_DEPTH; the FIFO therefore never overflows and no read data is lost.
REQ-028 The read address SHALL start at start_addr, increment by one word per issued read, and wrap from Wdepth-1 to 0.
REQ-029 After the last read is issued, the FSM SHALL move to DRAIN; it moves to FIN when nothing is in flight, the FIFO is empty, and the tlast beat has been accepted.
REQ-030 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-031 Data SHALL enter the FIFO exactly RD_LATENCY cycles after its bram_en cycle.
REQ-032 The stream output SHALL come from the FIFO head: tvalid = FIFO non-empty.
REQ-033 tdata and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-034 A beat transfers only when tvalid and tready are both 1.
REQ-035 tlast SHALL be 1 on exactly the length-th word and on no other word.
REQ-036 Latency: with start accepted at edge k and tready held at 1, bram_en SHALL be first high in cycle k+1, the first tvalid SHALL occur in cycle k+2+RD_LATENCY, and beats follow at one per cycle with no gaps.
REQ-037 An FIFO push and pop in the same cycle SHALL leave occupancy unchanged; a full FIFO with a pop in the same cycle SHALL allow a new issue in the following cycle.
REQ-038 abort=1 in any non-IDLE state SHALL, at the next edge, clear the FIFO and in-flight count, drop tvalid, and enter FIN; any data returning afterwards is discarded.
REQ-039 abort=1 while in IDLE SHALL have no effect.
REQ-040 If start and abort are both 1 in IDLE, abort SHALL win and the start is ignored.

Reset
REQ-041 resetn=0 SHALL immediately return the FSM to IDLE, independent of clk.
REQ-042 resetn=0 SHALL immediately force busy=0, done=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and set FIFO occupancy and in-flight count to 0.
REQ-043 Reset asserted mid-readout SHALL produce no done pulse; after resetn rises, the block is ready for a start on the first clock edge.

Verification
REQ-044 BRAM preloaded with word i = i; start_addr=0, length=8, tready=1 -> beats 0..7, tlast on 7, first tvalid 3 cycles after start (RD_LATENCY=1), done pulse after the tlast beat.
REQ-045 start_addr=4094, length=4 -> data 4094, 4095, 0, 1; bram_addr sequence 0x3FF8, 0x3FFC, 0x0000, 0x0004.
REQ-046 length=100 with tready randomly 50% low -> all 100 words in order, no duplicates or drops, tdata stable while stalled, bram_en never high with FIFO plus in-flight count at 4.
REQ-047 length=0 -> done pulses 2 cycles after start; no bram_en and no tvalid at any time.
REQ-048 abort asserted 5 beats into a 50-word readout -> tvalid low next cycle, done pulses, no further beats; a following start with length=2 yields exactly 2 beats, starting at its own start_addr.
REQ-049 resetn pulsed low during DRAIN -> all outputs 0 immediately, no done pulse; RD_LATENCY=2 rerun of REQ-044 gives first tvalid 4 cycles after start.

Source files
------------

// File: rtl/vinstru_reader_if.sv
// ---------------------------------------------------------------------------
// vinstru_reader_if
//   Stream bundle carrying capture words out of the BRAM reader.
//
//   Signals:
//     tdata  [31:0] word at the head of the output buffer
//     tvalid        head word is present
//     tready        sink accepts the head word this cycle
//     tlast         head word is the final word of the readout
//
//   Handshake: a beat transfers on a rising clk edge where tvalid and tready
//   are both 1. While tvalid=1 and tready=0 the source holds tdata/tlast
//   unchanged. tvalid never waits on tready. The only case where tvalid
//   drops without a transfer is an abort or a reset.
//
//   Modports:
//     master : reader side (drives tdata/tvalid/tlast, samples tready)
//     slave  : sink side
// ---------------------------------------------------------------------------
interface vinstru_reader_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/vinstru_reader.sv
// ---------------------------------------------------------------------------
// vinstru_reader
//   Reads a block of 32-bit words from a capture BRAM. The block starts at
//   start_addr and the address wraps at the end of the BRAM. The words are
//   streamed out through a small buffer, and tlast marks the final word.
//   BRAM reads are flow-controlled by credit: a read is issued only when
//   the buffer is sure to have room for its data.
//
//   Ports:
//     clk, resetn             clock, asynchronous active-low reset
//     start, abort            one-cycle readout request / cancel
//     start_addr, length      first word address, word count (capped at Wdepth)
//     busy, done              readout in progress / one-cycle completion pulse
//     bram_clk/rst/en/we/addr/din/dout   BRAM read port (byte addressing)
//     dbg_state               current FSM state (IDLE=0 READ=1 DRAIN=2 FIN=3)
//     m_axis                  output stream (master modport)
// ---------------------------------------------------------------------------
module vinstru_reader #(
   parameter int Wdepth     = 4096,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start,
   input  logic                      abort,
   input  logic [$clog2(Wdepth)-1:0] start_addr,
   input  logic [$clog2(Wdepth):0]   length,
   output logic                      busy,
   output logic                      done,
   output logic                      bram_clk,
   output logic                      bram_rst,
   output logic                      bram_en,
   output logic [3:0]                bram_we,
   output logic [$clog2(Wdepth)+1:0] bram_addr,
   output logic [31:0]               bram_din,
   input  logic [31:0]               bram_dout,
   output logic [1:0]                dbg_state,
   vinstru_reader_if.master          m_axis
);

   localparam int AW = $clog2(Wdepth);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   state_t                  state;
   logic [AW-1:0]           addr;
   logic [LW-1:0]           rem;       // reads still to issue after the current one
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           rcv;       // words pushed so far in this readout
   logic                    zero_len;
   logic [RD_LATENCY-1:0]   pipe;      // tracks issued reads until their data returns
   logic [31:0]             mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   last_mem;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;     // buffer occupancy
   logic [CW-1:0]           used;      // occupancy plus reads in flight
   logic [CW-1:0]           used_next;
   logic [LW-1:0]           eff_len;
   logic                    tvalid_i;
   logic                    push;
   logic                    pop;
   logic                    can_issue;
   logic                    abort_hit;

   assign bram_clk  = clk;
   assign bram_rst  = ~resetn;
   assign bram_we   = '0;
   assign bram_din  = '0;
   assign bram_addr = {addr, 2'b00};
   assign dbg_state = state;

   // tdata is gated so that it reads 0 whenever the buffer is empty. This
   // includes reset, because the storage array itself is not reset.
   assign tvalid_i      = (count != '0);
   assign m_axis.tvalid = tvalid_i;
   assign m_axis.tdata  = tvalid_i ? mem[rd_ptr] : '0;
   assign m_axis.tlast  = tvalid_i & last_mem[rd_ptr];

   always_comb begin
      pop       = tvalid_i & m_axis.tready;
      push      = pipe[RD_LATENCY-1] & ((state == READ) | (state == DRAIN));
      abort_hit = abort & ((state == READ) | (state == DRAIN));
      eff_len   = (length > LW'(Wdepth)) ? LW'(Wdepth) : length;
      // The credit is counted as it will stand in the cycle of the next read.
      // The read in the current cycle takes one slot. A pop in the current
      // cycle frees one slot, so a full buffer that is popped can issue
      // again in the very next cycle.
      used_next = used + CW'(bram_en) - CW'(pop);
      can_issue = (rem != '0) && (used_next < CW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr]      <= bram_dout;
         last_mem[wr_ptr] <= (rcv == len_q - 1'b1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bram_en  <= 1'b0;
         addr     <= '0;
         rem      <= '0;
         len_q    <= '0;
         rcv      <= '0;
         zero_len <= 1'b0;
         pipe     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         used     <= '0;
      end else begin
         pipe  <= (pipe << 1) | RD_LATENCY'(bram_en);
         count <= count + CW'(push) - CW'(pop);
         used  <= used_next;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            rcv    <= rcv + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start && !abort) begin
                  len_q <= eff_len;
                  rcv   <= '0;
                  addr  <= start_addr;
                  busy  <= 1'b1;
                  state <= READ;
                  if (eff_len == '0) begin
                     zero_len <= 1'b1;
                     rem      <= '0;
                     bram_en  <= 1'b0;
                  end else begin
                     zero_len <= 1'b0;
                     rem      <= eff_len - 1'b1;
                     bram_en  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rem == '0) begin
                  bram_en <= 1'b0;
                  if (zero_len) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (can_issue) begin
                  bram_en <= 1'b1;
                  addr    <= addr + 1'b1;
                  rem     <= rem - 1'b1;
               end else begin
                  bram_en <= 1'b0;
               end
            end
            DRAIN: begin
               // The tlast beat is the last word and no read follows it, so
               // accepting it means the buffer and the pipe are both empty.
               if (pop && m_axis.tlast) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Clearing the pipe means that late BRAM data is never pushed.
         if (abort_hit) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            bram_en <= 1'b0;
            pipe    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            used    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vinstru_reader.sv
// ---------------------------------------------------------------------------
// tb_vinstru_reader
//   Directed bench for vinstru_reader. The bench runs two instances that
//   share their inputs: u_dut1 with RD_LATENCY=1 and u_dut2 with
//   RD_LATENCY=2. Each BRAM model returns the word address as data.
// ---------------------------------------------------------------------------
module tb_vinstru_reader;
   localparam int WD = 4096;

   typedef struct {
      logic [11:0] addr;
      logic [12:0] len;
      int          exp_beats;
      int          exp_first_tv;
      int          exp_done_rel;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        start;
   logic        abort;
   logic [11:0] start_addr;
   logic [12:0] length;
   logic        tready;

   logic        busy1, done1, bclk1, brst1, en1;
   logic [3:0]  we1;
   logic [13:0] baddr1;
   logic [31:0] din1, dout1;
   logic [1:0]  dbg1;
   logic        busy2, done2, bclk2, brst2, en2;
   logic [3:0]  we2;
   logic [13:0] baddr2;
   logic [31:0] din2, dout2;
   logic [1:0]  dbg2;

   vinstru_reader_if ax1 ();
   vinstru_reader_if ax2 ();
   assign ax1.tready = tready;
   assign ax2.tready = tready;

   vinstru_reader #(.Wdepth(WD), .RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .start_addr(start_addr), .length(length), .busy(busy1), .done(done1),
      .bram_clk(bclk1), .bram_rst(brst1), .bram_en(en1), .bram_we(we1),
      .bram_addr(baddr1), .bram_din(din1), .bram_dout(dout1),
      .dbg_state(dbg1), .m_axis(ax1.master)
   );

   vinstru_reader #(.Wdepth(WD), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .start_addr(start_addr), .length(length), .busy(busy2), .done(done2),
      .bram_clk(bclk2), .bram_rst(brst2), .bram_en(en2), .bram_we(we2),
      .bram_addr(baddr2), .bram_din(din2), .bram_dout(dout2),
      .dbg_state(dbg2), .m_axis(ax2.master)
   );

   // BRAM models: word i holds the value i
   logic [11:0] rd1, rd2a, rd2b;
   always @(posedge clk) begin
      if (en1) rd1 <= baddr1[13:2];
      if (en2) rd2a <= baddr2[13:2];
      rd2b <= rd2a;
   end
   assign dout1 = {20'd0, rd1};
   assign dout2 = {20'd0, rd2b};

   // scoreboard state
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          mon_on = 1'b0;
   int          t0, rel;
   int          first_tv1, first_tv2, done_rel1, done_rel2;
   int          done_cnt1, done_cnt2, busy_at1, issued, popped, beat_cnt;
   logic [32:0] got1_q[$];
   logic [32:0] got2_q[$];
   logic [32:0] exp_q[$];
   logic [13:0] addr_q[$];
   logic        stall_prev;
   logic [31:0] prev_data;
   logic        prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: samples on the falling edge, pairing outputs with the inputs
   // that the next rising edge will see
   always @(negedge clk) begin
      if (mon_on) begin
         rel = cyc - t0;
         if (rel == 1) busy_at1 = busy1;
         if (en1) begin
            check("credit_lt4", {63'd0, (issued - popped) < 4}, 64'd1);
            issued++;
            addr_q.push_back(baddr1);
         end
         if (ax1.tvalid && first_tv1 < 0) first_tv1 = rel;
         if (stall_prev && ax1.tvalid)
            check("stall_hold", {31'd0, ax1.tlast, ax1.tdata}, {31'd0, prev_last, prev_data});
         if (ax1.tvalid && tready) begin
            got1_q.push_back({ax1.tlast, ax1.tdata});
            popped++;
            beat_cnt++;
         end
         stall_prev = ax1.tvalid && !tready;
         prev_data  = ax1.tdata;
         prev_last  = ax1.tlast;
         if (done1) begin done_cnt1++; done_rel1 = rel; end
         if (ax2.tvalid && first_tv2 < 0) first_tv2 = rel;
         if (ax2.tvalid && tready) got2_q.push_back({ax2.tlast, ax2.tdata});
         if (done2) begin done_cnt2++; done_rel2 = rel; end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [11:0] a, input logic [12:0] l);
      got1_q.delete(); got2_q.delete(); addr_q.delete();
      first_tv1 = -1; first_tv2 = -1; done_rel1 = -1; done_rel2 = -1;
      done_cnt1 = 0; done_cnt2 = 0; busy_at1 = 0;
      issued = 0; popped = 0; beat_cnt = 0; stall_prev = 1'b0;
      start_addr = a; length = l; start = 1'b1;
      t0 = cyc; mon_on = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done1(input int max, input bit rnd);
      for (int i = 0; i < max && done_cnt1 == 0; i++) begin
         if (rnd) tready = 1'($urandom_range(0, 1));
         step();
      end
      check("done_seen", {63'd0, done_cnt1 > 0}, 64'd1);
      tready = 1'b1;
      repeat (5) step();
   endtask

   task automatic build_exp(input logic [11:0] a, input int n);
      logic [11:0] wa;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         wa = a + 12'(i);
         exp_q.push_back({(i == n - 1), 20'd0, wa});
      end
   endtask

   task automatic cmp_beats(input string tag, input int which);
      int n;
      n = (which == 1) ? got1_q.size() : got2_q.size();
      check({tag, "_beats"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i),
               {31'd0, (which == 1) ? got1_q[i] : got2_q[i]}, {31'd0, exp_q[i]});
   endtask

   vec_t vt[6];

   initial begin
      vt[0] = '{12'd0,    13'd8,    8,    3, 11};
      vt[1] = '{12'd4094, 13'd4,    4,    3, 7};
      vt[2] = '{12'd10,   13'd1,    1,    3, 4};
      vt[3] = '{12'd0,    13'd0,    0,   -1, 2};
      vt[4] = '{12'd4093, 13'd6,    6,    3, 9};
      vt[5] = '{12'd5,    13'd5000, 4096, 3, 4099};

      resetn = 1'b0; start = 1'b0; abort = 1'b0; tready = 1'b1;
      start_addr = '0; length = '0;
      #1;
      check("rst_busy",  busy1, 0);
      check("rst_done",  done1, 0);
      check("rst_en",    en1, 0);
      check("rst_addr",  baddr1, 0);
      check("rst_tvalid", ax1.tvalid, 0);
      check("rst_tlast", ax1.tlast, 0);
      check("rst_tdata", ax1.tdata, 0);
      check("rst_bramrst", brst1, 1);
      check("rst_state", dbg1, 0);
      repeat (3) step();
      resetn = 1'b1;
      step();
      check("idle_we_din", {we1, din1}, 0);
      check("run_bramrst", brst1, 0);

      // start and abort together in IDLE: abort wins; abort alone does nothing
      start = 1'b1; abort = 1'b1; length = 13'd4;
      step();
      start = 1'b0; abort = 1'b0;
      step();
      check("startabort_busy", busy1, 0);
      check("startabort_state", dbg1, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("idleabort_state", dbg1, 0);
      check("idleabort_done", done1, 0);

      // table-driven readouts with tready held high
      for (int v = 0; v < 6; v++) begin
         tready = 1'b1;
         go(vt[v].addr, vt[v].len);
         wait_done1(5000, 1'b0);
         build_exp(vt[v].addr, vt[v].exp_beats);
         cmp_beats($sformatf("v%0d", v), 1);
         check($sformatf("v%0d_first_tv", v), first_tv1, vt[v].exp_first_tv);
         check($sformatf("v%0d_done_rel", v), done_rel1, vt[v].exp_done_rel);
         check($sformatf("v%0d_done_cnt", v), done_cnt1, 1);
         check($sformatf("v%0d_busy1", v), busy_at1, 1);
         check($sformatf("v%0d_reads", v), addr_q.size(), vt[v].exp_beats);
         for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++)
            check($sformatf("v%0d_addr%0d", v, i), addr_q[i], {exp_q[i][11:0], 2'b00});
      end

      // random backpressure
      go(12'd200, 13'd100);
      wait_done1(3000, 1'b1);
      build_exp(12'd200, 100);
      cmp_beats("stall", 1);
      check("stall_done_cnt", done_cnt1, 1);

      // abort after five beats of a 50-word readout
      tready = 1'b1;
      go(12'd300, 13'd50);
      for (int i = 0; i < 100 && beat_cnt < 5; i++) step();
      check("abort_reach5", beat_cnt, 5);
      tready = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_tvalid", ax1.tvalid, 0);
      check("abort_done", done1, 1);
      check("abort_state", dbg1, 3);
      tready = 1'b1;
      repeat (10) step();
      build_exp(12'd300, 50);
      exp_q = exp_q[0:4];
      cmp_beats("abort", 1);
      check("abort_done_cnt", done_cnt1, 1);
      go(12'd77, 13'd2);
      wait_done1(100, 1'b0);
      build_exp(12'd77, 2);
      cmp_beats("post_abort", 1);

      // reset while in DRAIN
      tready = 1'b0;
      go(12'd0, 13'd3);
      repeat (6) step();
      check("drain_state", dbg1, 2);
      check("drain_tvalid", ax1.tvalid, 1);
      #2 resetn = 1'b0;
      #1;
      check("mrst_busy",   busy1, 0);
      check("mrst_done",   done1, 0);
      check("mrst_en",     en1, 0);
      check("mrst_addr",   baddr1, 0);
      check("mrst_tvalid", ax1.tvalid, 0);
      check("mrst_tlast",  ax1.tlast, 0);
      check("mrst_tdata",  ax1.tdata, 0);
      check("mrst_state",  dbg1, 0);
      repeat (3) step();
      check("mrst_no_done", done_cnt1, 0);
      resetn = 1'b1;

      // start on the first edge after reset; compare both read latencies
      tready = 1'b1;
      go(12'd0, 13'd8);
      for (int i = 0; i < 100 && done_cnt2 == 0; i++) step();
      check("lat2_done_seen", {63'd0, done_cnt2 > 0}, 64'd1);
      repeat (3) step();
      build_exp(12'd0, 8);
      cmp_beats("lat1", 1);
      cmp_beats("lat2", 2);
      check("lat1_first_tv", first_tv1, 3);
      check("lat2_first_tv", first_tv2, 4);
      check("lat2_done_rel", done_rel2, 12);
      check("lat2_done_cnt", done_cnt2, 1);

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
